// File: rtl/trace_capture.sv
// Generic FIFO with optional overwrite-oldest mode for the trace buffer.
// Latency: a push is visible at the head one cycle later (first-word fall-through).
// Backpressure: pop only when pop_rdy & pop_vld; when full, a push is dropped or evicts the head.
module trace_fifo #(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0,
    parameter int CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count,
    output logic          overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          full;
    logic          empty;
    logic          do_pop;
    logic          do_write;
    logic          adv_head;
    logic          ovf_set;

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign do_pop = pop_rdy && !empty;

    // A pop frees a slot in the same cycle, so a full buffer with push+pop never loses data.
    always_comb begin
        do_write = 1'b0;
        adv_head = do_pop;
        ovf_set  = 1'b0;
        if (push_vld) begin
            if (!full || do_pop) begin
                do_write = 1'b1;
            end else if (OVERWRITE != 0) begin
                do_write = 1'b1;
                adv_head = 1'b1;
                ovf_set  = 1'b1;
            end else begin
                ovf_set  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (adv_head) rd_ptr <= rd_ptr + AW'(1);
            if (do_write && !adv_head) begin
                cnt <= cnt + CW'(1);
            end else if (!do_write && adv_head) begin
                cnt <= cnt - CW'(1);
            end
            if (ovf_set) ovf <= 1'b1;
        end
    end

    // Storage is deliberately not reset; contents are only observed while pop_vld is high.
    always_ff @(posedge clk) begin
        if (do_write && !flush) mem[wr_ptr] <= push_dat;
    end

    assign pop_vld  = !empty;
    assign pop_dat  = mem[rd_ptr];
    assign count    = cnt;
    assign overflow = ovf;
endmodule

// Retirement trace capture: records committed instructions and halts on stop-PC, cycle limit or request.
// Latency: a commit sampled at edge N appears on rd_* after edge N.
// Backpressure: rd_valid/rd_ready handshake; when full, new records drop or evict the oldest.
module trace_capture #(
    parameter int DEPTH      = 64,
    parameter int PC_W       = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_CYCLES = 1000,
    parameter int CNT_W      = 16,
    parameter int OVERWRITE  = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     halt_req,
    input  logic                     stop_pc_en,
    input  logic [PC_W-1:0]          stop_pc,
    input  logic                     commit_valid,
    input  logic [PC_W-1:0]          commit_pc,
    input  logic [PC_W-1:0]          commit_instr,
    input  logic                     commit_we,
    input  logic [4:0]               commit_rd,
    input  logic [DATA_W-1:0]        commit_wd,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [PC_W-1:0]          rd_pc,
    output logic [PC_W-1:0]          rd_instr,
    output logic                     rd_we,
    output logic [4:0]               rd_rd,
    output logic [DATA_W-1:0]        rd_wd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halted,
    output logic [1:0]               halt_cause,
    output logic [CNT_W-1:0]         cycle_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_STOP  = 2'd1;
    localparam logic [1:0] CAUSE_LIMIT = 2'd2;
    localparam logic [1:0] CAUSE_EXT   = 2'd3;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   instr;
        logic              we;
        logic [4:0]        rd;
        logic [DATA_W-1:0] wd;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       cause_nxt;
    logic [CNT_W-1:0] cyc_nxt;
    logic             push_vld;
    logic             stop_hit;
    logic             limit_hit;
    rec_t             push_rec;
    rec_t             head_rec;
    logic [REC_W-1:0] head_dat;

    assign stop_hit  = commit_valid && stop_pc_en && (commit_pc == stop_pc);
    assign limit_hit = ((cycle_cnt + CNT_W'(1)) == CNT_W'(MAX_CYCLES));
    assign push_rec  = {commit_pc, commit_instr, commit_we, commit_rd, commit_wd};

    // Halt sources are only evaluated in enabled RUN cycles; the halting commit is still recorded.
    always_comb begin
        state_nxt = state;
        cause_nxt = halt_cause;
        cyc_nxt   = cycle_cnt;
        push_vld  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            cause_nxt = CAUSE_NONE;
            cyc_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) state_nxt = RUN;
                end
                RUN: begin
                    if (en) begin
                        cyc_nxt  = cycle_cnt + CNT_W'(1);
                        push_vld = commit_valid;
                        if (stop_hit) begin
                            state_nxt = HALTED;
                            cause_nxt = CAUSE_STOP;
                        end else if (halt_req) begin
                            state_nxt = HALTED;
                            cause_nxt = CAUSE_EXT;
                        end else if (limit_hit) begin
                            state_nxt = HALTED;
                            cause_nxt = CAUSE_LIMIT;
                        end
                    end
                end
                HALTED: begin
                    state_nxt = HALTED;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            halt_cause <= CAUSE_NONE;
            cycle_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            halt_cause <= cause_nxt;
            cycle_cnt  <= cyc_nxt;
        end
    end

    trace_fifo #(
        .W         (REC_W),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE),
        .CW        (CW)
    ) u_buf (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (clear),
        .push_vld (push_vld),
        .push_dat (push_rec),
        .pop_rdy  (rd_ready),
        .pop_vld  (rd_valid),
        .pop_dat  (head_dat),
        .count    (count),
        .overflow (overflow)
    );

    assign head_rec = rec_t'(head_dat);
    assign rd_pc    = head_rec.pc;
    assign rd_instr = head_rec.instr;
    assign rd_we    = head_rec.we;
    assign rd_rd    = head_rec.rd;
    assign rd_wd    = head_rec.wd;
    assign halted   = (state == HALTED);
endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: two instances (stop-when-full and ring) against a queue-based model.
module tb_trace_capture;
    localparam int DEPTH = 4;
    localparam int MAXC  = 20;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } rec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic        halt_req = 1'b0;
    logic        stop_pc_en = 1'b0;
    logic [31:0] stop_pc = 32'h0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = 32'h0;
    logic [31:0] commit_instr = 32'h0;
    logic        commit_we = 1'b0;
    logic [4:0]  commit_rd = 5'h0;
    logic [31:0] commit_wd = 32'h0;
    logic        rd_ready = 1'b0;

    logic        rd_valid_w [2];
    logic [31:0] rd_pc_w    [2];
    logic [31:0] rd_instr_w [2];
    logic        rd_we_w    [2];
    logic [4:0]  rd_rd_w    [2];
    logic [31:0] rd_wd_w    [2];
    logic [2:0]  count_w    [2];
    logic        ovf_w      [2];
    logic        halted_w   [2];
    logic [1:0]  cause_w    [2];
    logic [15:0] cyc_w      [2];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        trace_capture #(
            .DEPTH(DEPTH), .PC_W(32), .DATA_W(32),
            .MAX_CYCLES(MAXC), .CNT_W(16), .OVERWRITE(g)
        ) dut (
            .clk(clk), .rstn(rstn), .en(en), .clear(clear), .halt_req(halt_req),
            .stop_pc_en(stop_pc_en), .stop_pc(stop_pc),
            .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
            .commit_we(commit_we), .commit_rd(commit_rd), .commit_wd(commit_wd),
            .rd_ready(rd_ready), .rd_valid(rd_valid_w[g]), .rd_pc(rd_pc_w[g]),
            .rd_instr(rd_instr_w[g]), .rd_we(rd_we_w[g]), .rd_rd(rd_rd_w[g]), .rd_wd(rd_wd_w[g]),
            .count(count_w[g]), .overflow(ovf_w[g]), .halted(halted_w[g]),
            .halt_cause(cause_w[g]), .cycle_cnt(cyc_w[g])
        );
    end

    task automatic chk(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 halted; buffer is a plain queue.
    rec_t mq [2][$];
    int   m_mode  [2];
    int   m_cyc   [2];
    int   m_cause [2];
    bit   m_ovf   [2];

    always @(posedge clk or negedge rstn) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn || clear) begin
                mq[k].delete();
                m_mode[k] = 0; m_cyc[k] = 0; m_cause[k] = 0; m_ovf[k] = 1'b0;
            end else begin
                bit   act;
                bit   pop;
                rec_t r;
                act = (m_mode[k] == 1) && en;
                pop = rd_ready && (mq[k].size() > 0);
                if (m_mode[k] == 0 && en) m_mode[k] = 1;
                if (act) begin
                    m_cyc[k]++;
                    if (commit_valid && stop_pc_en && commit_pc == stop_pc) begin
                        m_mode[k] = 2; m_cause[k] = 1;
                    end else if (halt_req) begin
                        m_mode[k] = 2; m_cause[k] = 3;
                    end else if (m_cyc[k] == MAXC) begin
                        m_mode[k] = 2; m_cause[k] = 2;
                    end
                end
                if (pop) void'(mq[k].pop_front());
                if (act && commit_valid) begin
                    r.pc = commit_pc; r.instr = commit_instr; r.we = commit_we;
                    r.rd = commit_rd; r.wd = commit_wd;
                    if (mq[k].size() < DEPTH) begin
                        mq[k].push_back(r);
                    end else if (k == 1) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(r);
                        m_ovf[k] = 1'b1;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk(k, "rd_valid", 64'(rd_valid_w[k]), 64'(mq[k].size() > 0));
                chk(k, "count", 64'(count_w[k]), 64'(mq[k].size()));
                chk(k, "overflow", 64'(ovf_w[k]), 64'(m_ovf[k]));
                chk(k, "halted", 64'(halted_w[k]), 64'(m_mode[k] == 2));
                chk(k, "halt_cause", 64'(cause_w[k]), 64'(m_cause[k]));
                chk(k, "cycle_cnt", 64'(cyc_w[k]), 64'(m_cyc[k]));
                if (mq[k].size() > 0) begin
                    rec_t h;
                    h = mq[k][0];
                    chk(k, "rd_pc", 64'(rd_pc_w[k]), 64'(h.pc));
                    chk(k, "rd_instr", 64'(rd_instr_w[k]), 64'(h.instr));
                    chk(k, "rd_we", 64'(rd_we_w[k]), 64'(h.we));
                    chk(k, "rd_rd", 64'(rd_rd_w[k]), 64'(h.rd));
                    chk(k, "rd_wd", 64'(rd_wd_w[k]), 64'(h.wd));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic commit(input logic [31:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_instr = $urandom;
        commit_we    = ($urandom_range(0, 1) == 1);
        commit_rd    = 5'($urandom_range(0, 31));
        commit_wd    = $urandom;
        cyc();
        commit_valid = 1'b0;
    endtask

    task automatic do_clear();
        en = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic start();
        en = 1'b1;
        cyc();
    endtask

    task automatic reset_lits(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk(k, {tag, "_rd_valid"}, 64'(rd_valid_w[k]), 64'd0);
            chk(k, {tag, "_count"}, 64'(count_w[k]), 64'd0);
            chk(k, {tag, "_overflow"}, 64'(ovf_w[k]), 64'd0);
            chk(k, {tag, "_halted"}, 64'(halted_w[k]), 64'd0);
            chk(k, {tag, "_cause"}, 64'(cause_w[k]), 64'd0);
            chk(k, {tag, "_cycle_cnt"}, 64'(cyc_w[k]), 64'd0);
        end
    endtask

    logic [31:0] exp0 [4];
    logic [31:0] exp1 [4];

    initial begin
        cyc(); cyc();
        chk_on = 1'b1;
        reset_lits("reset");
        rstn = 1'b1;
        cyc();

        // Basic capture then drain.
        start();
        commit(32'h0); commit(32'h4); commit(32'h8);
        chk(0, "basic_count", 64'(count_w[0]), 64'd3);
        chk(0, "basic_head", 64'(rd_pc_w[0]), 64'h0);
        rd_ready = 1'b1;
        chk(0, "basic_drain0", 64'(rd_pc_w[0]), 64'h0);
        cyc();
        chk(0, "basic_drain1", 64'(rd_pc_w[0]), 64'h4);
        cyc();
        chk(0, "basic_drain2", 64'(rd_pc_w[0]), 64'h8);
        cyc();
        rd_ready = 1'b0;
        chk(0, "basic_empty", 64'(rd_valid_w[0]), 64'd0);
        do_clear();

        // Full buffer in both modes, then push+pop while full, then paused drain.
        start();
        for (int i = 0; i < 6; i++) commit(32'(i * 4));
        for (int k = 0; k < 2; k++) begin
            chk(k, "full_count", 64'(count_w[k]), 64'd4);
            chk(k, "full_overflow", 64'(ovf_w[k]), 64'd1);
        end
        chk(0, "full_head_ow0", 64'(rd_pc_w[0]), 64'h0);
        chk(1, "full_head_ow1", 64'(rd_pc_w[1]), 64'h8);
        rd_ready = 1'b1;
        commit(32'h18);
        rd_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk(k, "pushpop_count", 64'(count_w[k]), 64'd4);
            chk(k, "pushpop_overflow", 64'(ovf_w[k]), 64'd1);
        end
        exp0 = '{32'h4, 32'h8, 32'hC, 32'h18};
        exp1 = '{32'hC, 32'h10, 32'h14, 32'h18};
        en = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk(0, "ow0_entry", 64'(rd_pc_w[0]), 64'(exp0[i]));
            chk(1, "ow1_entry", 64'(rd_pc_w[1]), 64'(exp1[i]));
            cyc();
        end
        rd_ready = 1'b0;
        chk(0, "paused_cycle_cnt", 64'(cyc_w[0]), 64'd7);
        do_clear();

        // Cycle limit.
        start();
        repeat (MAXC - 1) cyc();
        chk(0, "limit_not_yet", 64'(halted_w[0]), 64'd0);
        cyc();
        chk(0, "limit_halted", 64'(halted_w[0]), 64'd1);
        chk(0, "limit_cause", 64'(cause_w[0]), 64'd2);
        chk(0, "limit_cycle_cnt", 64'(cyc_w[0]), 64'd20);
        cyc();
        chk(0, "limit_frozen", 64'(cyc_w[0]), 64'd20);
        do_clear();
        reset_lits("clear_halted");

        // Stop-PC halt.
        stop_pc = 32'h198; stop_pc_en = 1'b1;
        start();
        commit(32'h190); commit(32'h194); commit(32'h198);
        chk(0, "stop_halted", 64'(halted_w[0]), 64'd1);
        chk(0, "stop_cause", 64'(cause_w[0]), 64'd1);
        commit(32'h19C);
        chk(0, "stop_no_capture", 64'(count_w[0]), 64'd3);
        rd_ready = 1'b1;
        cyc(); cyc();
        chk(0, "stop_last_pc", 64'(rd_pc_w[0]), 64'h198);
        cyc();
        rd_ready = 1'b0;
        do_clear();

        // Stop-PC outranks halt_req; halt_req alone is cause 3.
        start();
        halt_req = 1'b1;
        commit(32'h198);
        halt_req = 1'b0;
        chk(0, "prio_cause", 64'(cause_w[0]), 64'd1);
        do_clear();
        stop_pc_en = 1'b0;
        start();
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        chk(1, "ext_cause", 64'(cause_w[1]), 64'd3);
        do_clear();

        // Asynchronous reset mid-run with data and overflow present.
        start();
        for (int i = 0; i < 5; i++) commit(32'h10 + 32'(i * 4));
        chk(0, "prereset_overflow", 64'(ovf_w[0]), 64'd1);
        rstn = 1'b0;
        #1;
        reset_lits("midrun_reset");
        cyc();
        rstn = 1'b1;
        cyc();

        // Randomised traffic.
        stop_pc = 32'h40;
        for (int i = 0; i < 3000; i++) begin
            rstn         = ($urandom_range(0, 299) != 0);
            en           = ($urandom_range(0, 3) != 0);
            clear        = ($urandom_range(0, 24) == 0);
            halt_req     = ($urandom_range(0, 39) == 0);
            stop_pc_en   = ($urandom_range(0, 1) == 1);
            commit_valid = ($urandom_range(0, 1) == 1);
            commit_pc    = 32'($urandom_range(0, 31)) << 2;
            commit_instr = $urandom;
            commit_we    = ($urandom_range(0, 1) == 1);
            commit_rd    = 5'($urandom_range(0, 31));
            commit_wd    = $urandom;
            rd_ready     = ($urandom_range(0, 2) == 0);
            cyc();
        end
        rstn = 1'b1;
        cyc();
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
